// File: rtl/drive_regulator.sv
// Closed-loop motor current regulator: decimated PI + D controller producing the PWM drive
// magnitude, with saturation on the error, integrator, derivative and output.
module drive_regulator #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        not_pedaling,
  output logic [11:0] drv_mag,
  output logic        decim_tick
);

  logic signed [12:0] w_err;
  logic signed [9:0]  w_err_sat;
  logic signed [9:0]  r_err_q;
  logic [16:0]        r_integ;
  logic signed [18:0] w_integ_sum;
  logic [16:0]        w_integ_nxt;
  logic signed [9:0]  r_hist0, r_hist1, r_hist2;
  logic signed [10:0] w_d_diff;
  logic signed [8:0]  w_d_sat;
  logic signed [13:0] w_p, w_i, w_d, w_pid;
  logic [11:0]        w_drv_nxt;
  logic [19:0]        r_decim_cnt;

  assign w_err = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});

  always_comb begin
    w_err_sat = w_err[9:0];
    if (w_err > 13'sd511) begin
      w_err_sat = 10'h1FF;
    end else if (w_err < -13'sd512) begin
      w_err_sat = 10'h200;
    end
  end

  assign decim_tick = FAST_SIM ? (&r_decim_cnt[14:0]) : (&r_decim_cnt);

  // Integrator accumulates unsigned; the sum is widened so both clamps are detectable.
  assign w_integ_sum = $signed({2'b00, r_integ}) + $signed({{9{r_err_q[9]}}, r_err_q});

  always_comb begin
    w_integ_nxt = w_integ_sum[16:0];
    if (w_integ_sum < 19'sd0) begin
      w_integ_nxt = 17'h00000;
    end else if (w_integ_sum > 19'sh1FFFF) begin
      w_integ_nxt = 17'h1FFFF;
    end
  end

  assign w_d_diff = $signed({r_err_q[9], r_err_q}) - $signed({r_hist2[9], r_hist2});

  always_comb begin
    w_d_sat = w_d_diff[8:0];
    if (w_d_diff > 11'sd255) begin
      w_d_sat = 9'h0FF;
    end else if (w_d_diff < -11'sd256) begin
      w_d_sat = 9'h100;
    end
  end

  assign w_p   = {{4{r_err_q[9]}}, r_err_q};
  assign w_i   = {2'b00, r_integ[16:5]};
  assign w_d   = {{3{w_d_sat[8]}}, w_d_sat, 2'b00};
  assign w_pid = w_p + w_i + w_d;

  always_comb begin
    w_drv_nxt = w_pid[11:0];
    if (w_pid < 14'sd0) begin
      w_drv_nxt = 12'h000;
    end else if (w_pid > 14'sd4095) begin
      w_drv_nxt = 12'hFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q     <= '0;
      r_integ     <= '0;
      r_hist0     <= '0;
      r_hist1     <= '0;
      r_hist2     <= '0;
      r_decim_cnt <= '0;
      drv_mag     <= '0;
    end else begin
      r_err_q     <= w_err_sat;
      r_decim_cnt <= r_decim_cnt + 20'd1;
      if (decim_tick) begin
        r_hist2 <= r_hist1;
        r_hist1 <= r_hist0;
        r_hist0 <= r_err_q;
      end
      // Pedal release restarts the integrator from zero, even on a tick edge.
      if (not_pedaling) begin
        r_integ <= '0;
      end else if (decim_tick) begin
        r_integ <= w_integ_nxt;
      end
      drv_mag <= not_pedaling ? 12'h000 : w_drv_nxt;
    end
  end

endmodule

// File: doc/drive_regulator.md
# drive_regulator

Closed-loop motor current regulator for the eBike drive path. Consumes the commanded `target_curr` from the assist computation and the filtered measured motor current, and produces the PWM drive magnitude `drv_mag` through a decimated PI + D controller with saturation at every stage. It sits between the assist computation and the commutation/PWM logic.

## Interface
- `FAST_SIM`, default 1'b0: when 1, the decimator period is shortened from 2^20 to 2^15 clocks for simulation.

- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `target_curr`  input  12  commanded current, unsigned
- `avg_curr`  input  12  measured/averaged motor current, unsigned
- `not_pedaling`  input  1  rider not pedaling; clears the integrator and forces zero drive
- `drv_mag`  output  12  drive magnitude to PWM, unsigned, registered
- `decim_tick`  output  1  one-cycle pulse marking an integrator/derivative update (test/debug)

## Operation
- Error: `err = {1'b0,target_curr} - {1'b0,avg_curr}`, 13-bit signed. Saturate to 10-bit signed [-512, 511] to form `err_sat`, then register it as `err_q`.
- Decimator: a 20-bit free-running counter `decim_cnt` that increments every clock and wraps.
  - `decim_tick` = 1 when all 20 bits are 1, or, with FAST_SIM, when the low 15 bits are all 1.
  - Period is exactly 2^20 (or 2^15) clocks. `decim_tick` is combinational from the counter.
- P term: `err_q` sign-extended to 14 bits.
- I term: 17-bit unsigned integrator `integ`.
  - On `decim_tick`, compute the 19-bit signed value `integ + sext(err_q)`.
  - If the result is < 0, load 0. If it is > 0x1FFFF, load 0x1FFFF. Otherwise load the result.
  - I term = `{2'b00, integ[16:5]}` (14 bits).
- D term: a 3-deep history `hist0..hist2` of `err_q` values, each 10-bit signed.
  - On `decim_tick`: hist2 <= hist1, hist1 <= hist0, hist0 <= err_q.
  - `d_diff = err_q - hist2`, 11-bit signed, saturated to 9-bit signed [-256, 255].
  - D term = that saturated value × 4, sign-extended to 14 bits.
- Sum: `pid = P + I + D`, 14-bit signed (it cannot overflow at these ranges).
  - `drv_mag` <= 0 if `pid` < 0.
  - `drv_mag` <= 0xFFF if `pid` > 4095.
  - Otherwise `drv_mag` <= `pid[11:0]`.
- `not_pedaling` = 1, checked each clock:
  - `integ` <= 0. This has priority over a coincident `decim_tick`.
  - `drv_mag` <= 0.
  - The history registers and `decim_cnt` keep running.
- Reset (asynchronous, `rst_n` = 0) clears all state: `err_q`, `integ`, `hist0..2`, `decim_cnt`, and `drv_mag`.
  - Resulting output values: `drv_mag` = 0, `decim_tick` = 0 (counter = 0).
  - Reset may assert at any cycle and takes effect immediately.

## Timing
- Input to `err_q`: 1 clock. `err_q` to `drv_mag`: 1 clock. Total latency from a `target_curr`/`avg_curr` change to `drv_mag` is 2 clocks (P and D paths).
- Integrator and history update on the clock edge where `decim_tick` = 1, using the current `err_q`. The I-term effect appears on `drv_mag` one clock later.
- First `decim_tick` after reset release occurs at clock 2^20 − 1 (or 2^15 − 1 with FAST_SIM) after reset release.
- `not_pedaling`: `integ` and `drv_mag` are 0 on the first edge after it is sampled high. On release, `drv_mag` follows the P + D path from the next edge, and `integ` restarts from 0.
- No handshakes; the block is always ready and inputs are sampled every clock.

## Test plan
All scenarios use FAST_SIM = 1.

1. Reset and hold: `rst_n` low mid-run → `drv_mag` = 0 immediately. Release with `target_curr` = `avg_curr` = 0x300 → `drv_mag` stays 0 indefinitely and `decim_tick` pulses every 32768 clocks.
2. Small error step: `target_curr` = 0x0A0, `avg_curr` = 0x080 (err = 32).
   - 2 clocks later: `drv_mag` = 0x0A0 (P 32 + D 128).
   - After tick 1: 0x0A1. After tick 3: 0x023 (P 32 + I 3 + D 0).
3. Error saturation: `target_curr` = 0xFFF, `avg_curr` = 0 → `err_q` = 511, D = 1020, `drv_mag` = 0x5FB before the first tick.
4. Integrator clamp: hold err = 511 for 300 ticks → `integ` reaches and stays at 0x1FFFF after tick 257; `drv_mag` = 0xFFF.
5. Negative error: `target_curr` = 0, `avg_curr` = 0x100 → `integ` stays 0 across ticks, `drv_mag` = 0.
6. `not_pedaling` pulse: assert during scenario 4, coincident with a `decim_tick` → `integ` = 0 and `drv_mag` = 0 next clock. Deassert → `drv_mag` = 0x1FF + D contribution, and `integ` regrows by 511 per tick.
